x_mem_arb: RTL and testbench
============================

// Module: x_mem_arb
// PURPOSE
//  - Two-master arbiter sharing one memory port between the rv32i core (port 0) and a second master (port 1, debug/DMA).
//  - Every port uses the core's memory protocol: valid/rnw/addr/data out, accept/data back.
//  - Sits between x_top_rv32i and the memory/peripheral decode; one transaction in flight at a time.
// PARAMETERS
//  - AW            32  address width
//  - DW            32  data width
//  - STARVE_LIMIT  4   port-0 grants allowed while port 1 waits (only used with X_MEM_ARB_FAIR_EN); >=1
// PORTS
//  - i_clk          in   1   clock, all state on rising edge
//  - i_rst          in   1   reset, synchronous, active-high
//  - i_m0_valid     in   1   port 0 request; held until o_m0_accept
//  - i_m0_rnw       in   1   port 0 read(1)/write(0)
//  - i_m0_addr      in   AW  port 0 address
//  - i_m0_data      in   DW  port 0 write data
//  - o_m0_accept    out  1   port 0 transaction complete (1-cycle pulse)
//  - o_m0_data      out  DW  port 0 read data, valid with o_m0_accept
//  - i_m1_*/o_m1_*  --   --  port 1, identical set to port 0
//  - o_mem_valid    out  1   downstream request
//  - o_mem_rnw      out  1   downstream read/write
//  - o_mem_addr     out  AW  downstream address
//  - o_mem_data     out  DW  downstream write data
//  - i_mem_accept   in   1   downstream completion pulse
//  - i_mem_data     in   DW  downstream read data, valid with i_mem_accept
//  - o_grant        out  2   one-hot current grant {m1,m0}; 0 when idle
// BEHAVIOUR
//  - State reg sm_q: IDLE, GNT0, GNT1. Reset (i_rst high at clock edge) -> IDLE.
//  - IDLE: no request -> IDLE; else pick winner (see arbitration) -> GNT0/GNT1 next cycle.
//  - GNTn: o_mem_* = port n inputs combinationally; o_mem_valid = i_mn_valid.
//  - GNTn: o_mn_accept = i_mem_accept (comb); o_mn_data = i_mem_data; other port accept = 0.
//  - GNTn & i_mem_accept -> IDLE. One idle bubble between transactions, always.
//  - GNTn & !i_mn_valid (master abandons, protocol violation) -> IDLE next cycle, no accept issued.
//  - Latency: request seen in IDLE cycle T -> o_mem_valid at T+1 -> accept same cycle as i_mem_accept.
//  - IDLE: o_mem_valid=0, o_mem_rnw=1, o_mem_addr=0, o_mem_data=0; i_mem_accept ignored, no accept to masters.
//  - o_m0_data/o_m1_data = i_mem_data always (qualified only by accept).
//  - Reset values (state IDLE): o_mem_valid=0, o_mem_rnw=1, o_mem_addr=0, o_mem_data=0, o_m0/1_accept=0, o_grant=0.
//  - Reset mid-transaction: state forced to IDLE at that edge; transaction dropped, no accept; starve counter cleared.
//  - Arbitration (base): fixed priority, port 0 wins when both valid in IDLE.
//  - Grant decided only in IDLE; requests arriving during GNTn wait for next IDLE.
// CONFIGURATION
//  - X_MEM_ARB_FAIR_EN undefined: fixed priority as above; no counter logic.
//  - X_MEM_ARB_FAIR_EN defined: counter starve_q, width $clog2(STARVE_LIMIT+1), reset 0.
//    - IDLE->GNT0 while i_m1_valid: starve_q++ (saturating at STARVE_LIMIT).
//    - IDLE with both valid and starve_q==STARVE_LIMIT: port 1 wins.
//    - Any IDLE->GNT1: starve_q<=0.
//    - IDLE with !i_m1_valid: starve_q<=0.
// TESTING
//  - Reset: hold i_rst 2 cycles with both valids high -> o_grant=0, o_mem_valid=0, no accepts; release -> GNT0 one cycle later.
//  - Single read m0 addr 0x100, mem accepts 3 cycles later with 0xDEADBEEF -> o_m0_accept 1 cycle, o_m0_data=0xDEADBEEF.
//  - Both valid, m0 write 0x200<-0x5, m1 read 0x300 -> m0 first, IDLE bubble, then m1 on o_mem_addr=0x300.
//  - m0 valid permanently, m1 valid (no FAIR_EN) -> m1 never granted in 20 transactions.
//  - Same with FAIR_EN, STARVE_LIMIT=4 -> grant order 0,0,0,0,1 repeating; o_mem_addr follows.
//  - i_rst during GNT1 with i_mem_accept high same cycle -> no o_m1_accept, state IDLE, o_mem_valid=0 next cycle.

Source files
------------

// File: rtl/x_mem_arb.sv
// x_mem_arb: two-master arbiter sharing one memory port.
// Port 0 is the rv32i core, port 1 is a debug/DMA master. Only one transaction is in
// flight at a time, and there is always one idle cycle between transactions.
// Optional feature: define X_MEM_ARB_FAIR_EN to bound how long port 1 can be starved
// (after STARVE_LIMIT consecutive port-0 grants, port 1 wins).
module x_mem_arb #(
   parameter int unsigned AW           = 32,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_m0_valid,
   input  logic          i_m0_rnw,
   input  logic [AW-1:0] i_m0_addr,
   input  logic [DW-1:0] i_m0_data,
   output logic          o_m0_accept,
   output logic [DW-1:0] o_m0_data,
   input  logic          i_m1_valid,
   input  logic          i_m1_rnw,
   input  logic [AW-1:0] i_m1_addr,
   input  logic [DW-1:0] i_m1_data,
   output logic          o_m1_accept,
   output logic [DW-1:0] o_m1_data,
   output logic          o_mem_valid,
   output logic          o_mem_rnw,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_data,
   input  logic          i_mem_accept,
   input  logic [DW-1:0] i_mem_data,
   output logic [1:0]    o_grant
);

   if (STARVE_LIMIT < 1) begin : g_bad_starve_limit
      $error("x_mem_arb: STARVE_LIMIT must be at least 1");
   end

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StGnt0 = 2'd1,
      StGnt1 = 2'd2
   } sm_e;

   sm_e  r_sm;
   sm_e  w_sm_nxt;
   logic w_pick1;  // winner when a grant is decided in idle: 1 = port 1

   // Read data is broadcast; masters qualify it with their accept
   assign o_m0_data = i_mem_data;
   assign o_m1_data = i_mem_data;

`ifdef X_MEM_ARB_FAIR_EN
   localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0] r_starve;
   logic [SW-1:0] w_starve_nxt;
   logic          w_starved;

   assign w_starved = (r_starve == SW'(STARVE_LIMIT));
   assign w_pick1   = i_m1_valid & (~i_m0_valid | w_starved);

   // Count port-0 grants taken while port 1 is waiting; cleared once port 1 is served or idle
   always_comb begin
      w_starve_nxt = r_starve;
      if (r_sm == StIdle) begin
         if (!i_m1_valid || w_pick1) begin
            w_starve_nxt = '0;
         end else if (!w_starved) begin
            w_starve_nxt = r_starve + SW'(1);
         end
      end
   end

   // Starvation counter register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_starve <= '0;
      end else begin
         r_starve <= w_starve_nxt;
      end
   end
`else
   assign w_pick1 = i_m1_valid & ~i_m0_valid;
`endif

   // Arbiter state register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sm <= StIdle;
      end else begin
         r_sm <= w_sm_nxt;
      end
   end

   // Next state and port muxing; accepts are suppressed while reset is asserted
   always_comb begin
      w_sm_nxt    = r_sm;
      o_mem_valid = 1'b0;
      o_mem_rnw   = 1'b1;
      o_mem_addr  = '0;
      o_mem_data  = '0;
      o_m0_accept = 1'b0;
      o_m1_accept = 1'b0;
      o_grant     = 2'b00;
      unique case (r_sm)
         StIdle: begin
            if (i_m0_valid || i_m1_valid) begin
               w_sm_nxt = w_pick1 ? StGnt1 : StGnt0;
            end
         end
         StGnt0: begin
            o_mem_valid = i_m0_valid;
            o_mem_rnw   = i_m0_rnw;
            o_mem_addr  = i_m0_addr;
            o_mem_data  = i_m0_data;
            o_m0_accept = i_mem_accept & i_m0_valid & ~i_rst;
            o_grant     = 2'b01;
            if (!i_m0_valid || i_mem_accept) begin
               w_sm_nxt = StIdle;
            end
         end
         StGnt1: begin
            o_mem_valid = i_m1_valid;
            o_mem_rnw   = i_m1_rnw;
            o_mem_addr  = i_m1_addr;
            o_mem_data  = i_m1_data;
            o_m1_accept = i_mem_accept & i_m1_valid & ~i_rst;
            o_grant     = 2'b10;
            if (!i_m1_valid || i_mem_accept) begin
               w_sm_nxt = StIdle;
            end
         end
         default: begin
            w_sm_nxt = StIdle;
         end
      endcase
   end

endmodule

// File: tb/tb_x_mem_arb.sv
// Testbench for x_mem_arb: cycle-by-cycle vector table plus starvation and
// reset-during-grant sequences. Honors X_MEM_ARB_FAIR_EN when defined.
module tb_x_mem_arb;

   logic        clk = 1'b0;
   logic        rst;
   logic        m0_valid, m0_rnw, m0_accept;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_valid, m1_rnw, m1_accept;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic        mem_valid, mem_rnw, mem_accept;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic [1:0]  grant;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   x_mem_arb #(
      .AW           (32),
      .DW           (32),
      .STARVE_LIMIT (4)
   ) u_dut (
      .i_clk        (clk),
      .i_rst        (rst),
      .i_m0_valid   (m0_valid),
      .i_m0_rnw     (m0_rnw),
      .i_m0_addr    (m0_addr),
      .i_m0_data    (m0_wdata),
      .o_m0_accept  (m0_accept),
      .o_m0_data    (m0_rdata),
      .i_m1_valid   (m1_valid),
      .i_m1_rnw     (m1_rnw),
      .i_m1_addr    (m1_addr),
      .i_m1_data    (m1_wdata),
      .o_m1_accept  (m1_accept),
      .o_m1_data    (m1_rdata),
      .o_mem_valid  (mem_valid),
      .o_mem_rnw    (mem_rnw),
      .o_mem_addr   (mem_addr),
      .o_mem_data   (mem_wdata),
      .i_mem_accept (mem_accept),
      .i_mem_data   (mem_rdata),
      .o_grant      (grant)
   );

   typedef struct {
      logic        rst;
      logic        m0v;
      logic        m0rnw;
      logic [31:0] m0a;
      logic [31:0] m0d;
      logic        m1v;
      logic        m1rnw;
      logic [31:0] m1a;
      logic [31:0] m1d;
      logic        macc;
      logic [31:0] mdat;
      // expected
      logic        ev;
      logic        ernw;
      logic [31:0] ea;
      logic [31:0] ed;
      logic        eacc0;
      logic        eacc1;
      logic [1:0]  egnt;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      rst        = v.rst;
      m0_valid   = v.m0v;
      m0_rnw     = v.m0rnw;
      m0_addr    = v.m0a;
      m0_wdata   = v.m0d;
      m1_valid   = v.m1v;
      m1_rnw     = v.m1rnw;
      m1_addr    = v.m1a;
      m1_wdata   = v.m1d;
      mem_accept = v.macc;
      mem_rdata  = v.mdat;
   endtask

   // Move to 1 time unit after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [127:0] outs();
      return 128'({mem_valid, mem_rnw, mem_addr, mem_wdata, m0_accept, m1_accept, grant});
   endfunction

   function automatic logic [127:0] exp_outs(input vec_t v);
      return 128'({v.ev, v.ernw, v.ea, v.ed, v.eacc0, v.eacc1, v.egnt});
   endfunction

   initial begin
      //           rst m0v rnw m0a       m0d    m1v rnw m1a       m1d macc mdat
      //           | ev ernw ea         ed     acc0 acc1 gnt
      vecs[0]  = '{1, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      vecs[1]  = '{1, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      vecs[2]  = '{0, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      vecs[3]  = '{0, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   1, 1, 32'h100, 32'h0, 0, 0, 2'b01};
      vecs[4]  = '{0, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   1, 1, 32'h100, 32'h0, 0, 0, 2'b01};
      vecs[5]  = '{0, 1, 1, 32'h100, 32'h0, 1, 1, 32'h300, 32'h0, 1, 32'hDEADBEEF,
                   1, 1, 32'h100, 32'h0, 1, 0, 2'b01};
      // idle bubble: stray mem accept must be ignored
      vecs[6]  = '{0, 1, 0, 32'h200, 32'h5, 1, 1, 32'h300, 32'h0, 1, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      vecs[7]  = '{0, 1, 0, 32'h200, 32'h5, 1, 1, 32'h300, 32'h0, 1, 32'h0,
                   1, 0, 32'h200, 32'h5, 1, 0, 2'b01};
      vecs[8]  = '{0, 0, 1, 32'h0,   32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      vecs[9]  = '{0, 0, 1, 32'h0,   32'h0, 1, 1, 32'h300, 32'h0, 0, 32'h0,
                   1, 1, 32'h300, 32'h0, 0, 0, 2'b10};
      vecs[10] = '{0, 0, 1, 32'h0,   32'h0, 1, 1, 32'h300, 32'h0, 1, 32'h12345678,
                   1, 1, 32'h300, 32'h0, 0, 1, 2'b10};
      vecs[11] = '{0, 1, 1, 32'h400, 32'h0, 0, 1, 32'h0,   32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};
      // master abandons its request: valid drops, no accept, back to idle
      vecs[12] = '{0, 0, 1, 32'h400, 32'h0, 0, 1, 32'h0,   32'h0, 0, 32'h0,
                   0, 1, 32'h400, 32'h0, 0, 0, 2'b01};
      vecs[13] = '{0, 0, 1, 32'h0,   32'h0, 0, 1, 32'h0,   32'h0, 0, 32'h0,
                   0, 1, 32'h0,   32'h0, 0, 0, 2'b00};

      drive(vecs[0]);
      step();
      for (int i = 0; i < 14; i++) begin
         drive(vecs[i]);
         @(negedge clk);
         chk($sformatf("vec%0d", i), outs(), exp_outs(vecs[i]));
         if (vecs[i].eacc0) chk($sformatf("vec%0d_m0_data", i), 128'(m0_rdata), 128'(vecs[i].mdat));
         if (vecs[i].eacc1) chk($sformatf("vec%0d_m1_data", i), 128'(m1_rdata), 128'(vecs[i].mdat));
         step();
      end

      // Starvation: both masters request continuously for 20 transactions
      begin
         int          starve = 0;
         logic        exp_p1;
         mem_accept = 1'b0;
         mem_rdata  = 32'hA5A5_0000;
         m0_valid = 1'b1; m0_rnw = 1'b1; m0_addr = 32'h1000; m0_wdata = 32'h0;
         m1_valid = 1'b1; m1_rnw = 1'b1; m1_addr = 32'h2000; m1_wdata = 32'h0;
         rst = 1'b1;
         step();
         rst = 1'b0;
         for (int t = 0; t < 20; t++) begin
`ifdef X_MEM_ARB_FAIR_EN
            if (starve == 4) begin
               exp_p1 = 1'b1;
               starve = 0;
            end else begin
               exp_p1 = 1'b0;
               starve++;
            end
`else
            exp_p1 = 1'b0;
            starve = 0;
`endif
            mem_accept = 1'b0;
            @(negedge clk);
            chk($sformatf("starve%0d_idle_grant", t), 128'(grant), 128'(2'b00));
            step();
            mem_accept = 1'b1;
            @(negedge clk);
            chk($sformatf("starve%0d_grant", t), 128'(grant),
                128'(exp_p1 ? 2'b10 : 2'b01));
            chk($sformatf("starve%0d_addr", t), 128'(mem_addr),
                128'(exp_p1 ? 32'h2000 : 32'h1000));
            chk($sformatf("starve%0d_accepts", t), 128'({m1_accept, m0_accept}),
                128'(exp_p1 ? 2'b10 : 2'b01));
            step();
         end
         mem_accept = 1'b0;
      end

      // Reset while port 1 is granted and memory accepts in that same cycle
      rst = 1'b1;
      m0_valid = 1'b0;
      m1_valid = 1'b1; m1_rnw = 1'b1; m1_addr = 32'h300;
      step();
      rst = 1'b0;
      step();  // idle cycle, grants port 1
      @(negedge clk);
      chk("rst_gnt1_grant", 128'(grant), 128'(2'b10));
      step();
      rst = 1'b1;
      mem_accept = 1'b1;
      mem_rdata = 32'hCAFE_F00D;
      @(negedge clk);
      chk("rst_gnt1_no_accept", 128'({m1_accept, m0_accept}), 128'(2'b00));
      step();
      rst = 1'b0;
      mem_accept = 1'b0;
      @(negedge clk);
      chk("rst_gnt1_after_valid", 128'(mem_valid), 128'(1'b0));
      chk("rst_gnt1_after_grant", 128'(grant), 128'(2'b00));
      step();
      @(negedge clk);
      chk("rst_gnt1_regrant", 128'(grant), 128'(2'b10));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
